cpack_line_ctrl: RTL and testbench

Line-level sequencer for the two-word-per-cycle compression datapath (stage1and2 plus its dictionary).
- Accepts one uncompressed cache line over a valid/ready handshake.
- Pulses a dictionary clear, then issues the line as consecutive 64-bit word pairs while honouring packer backpressure.
- Accumulates the per-word compressed lengths returned by the datapath.
- Reports the total compressed size and a compressible verdict to the line packer.

---
 rtl/cpack_pkg.sv | 28 ++
 rtl/cpack_line_ctrl.sv | 140 ++++++++++++++
 tb/tb_cpack_line_ctrl.sv | 165 ++++++++++++++++
 3 files changed

// File: rtl/cpack_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | cpack_pkg: shared types and constants for the compression line path  |
// | Rev 1.0                                                              |
// +----------------------------------------------------------------------+
package cpack_pkg;

  localparam int WORD          = 32;
  localparam int WIDTH         = 64;
  localparam int MAX_WORD_LEN  = 34;
  localparam int CODE_ZZZZ_LEN = 2;
  localparam int CODE_MMMM_LEN = 6;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_CLEAR = 3'd1,
    ST_ISSUE = 3'd2,
    ST_DRAIN = 3'd3,
    ST_DONE  = 3'd4
  } ctrl_state_e;

  // Bits needed to hold the worst-case compressed size of n_pairs word pairs.
  function automatic int tot_width(input int n_pairs);
    return $clog2(n_pairs * 2 * MAX_WORD_LEN + 1);
  endfunction

endpackage
`default_nettype wire

// File: rtl/cpack_line_ctrl.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | cpack_line_ctrl: issues one cache line as word pairs, sums lengths   |
// | Rev 1.0                                                              |
// +----------------------------------------------------------------------+
module cpack_line_ctrl #(
  parameter int CACHE_LINE = 512,
  parameter int WIDTH      = 64,
  parameter int WORD       = 32,
  parameter int LEN_W      = 7,
  parameter int NUM_PAIRS  = CACHE_LINE / WIDTH,
  parameter int TOT_W      = cpack_pkg::tot_width(NUM_PAIRS)
) (
  input  logic                  i_clk,
  input  logic                  i_reset,
  input  logic                  i_line_valid,
  output logic                  o_line_ready,
  input  logic [CACHE_LINE-1:0] i_line,
  output logic [WIDTH-1:0]      o_word,
  output logic                  o_word_valid,
  output logic                  o_dict_clear,
  input  logic                  i_stall,
  input  logic                  i_len_valid,
  input  logic [LEN_W-1:0]      i_length1,
  input  logic [LEN_W-1:0]      i_length2,
  output logic                  o_done,
  output logic [TOT_W-1:0]      o_total_bits,
  output logic                  o_compressible,
  input  logic                  i_done_ack,
  output logic                  o_busy,
  output logic                  o_protocol_err
);
  import cpack_pkg::*;

  localparam int IDX_W = (NUM_PAIRS > 1) ? $clog2(NUM_PAIRS) : 1;
  localparam int CNT_W = $clog2(NUM_PAIRS + 1);

  ctrl_state_e           state_q, state_d;
  logic [CACHE_LINE-1:0] line_q, line_d;
  logic [IDX_W-1:0]      idx_q, idx_d;
  logic [CNT_W-1:0]      rcv_q, rcv_d;
  logic [TOT_W-1:0]      total_q, total_d;
  logic [WIDTH-1:0]      word_q, word_d;
  logic                  err_q, err_d;

  logic [WIDTH-1:0]      pair_sel;
  logic [TOT_W-1:0]      len_sum;
  logic                  len_ok;

  assign pair_sel = line_q[int'(idx_q) * 2 * WORD +: WIDTH];
  assign len_sum  = TOT_W'(i_length1) + TOT_W'(i_length2);
  assign len_ok   = ((state_q == ST_ISSUE) || (state_q == ST_DRAIN)) &&
                    (rcv_q < CNT_W'(NUM_PAIRS));

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      state_q <= ST_IDLE;
      line_q  <= '0;
      idx_q   <= '0;
      rcv_q   <= '0;
      total_q <= '0;
      word_q  <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      line_q  <= line_d;
      idx_q   <= idx_d;
      rcv_q   <= rcv_d;
      total_q <= total_d;
      word_q  <= word_d;
      err_q   <= err_d;
    end
  end

  always_comb begin
    state_d      = state_q;
    line_d       = line_q;
    idx_d        = idx_q;
    rcv_d        = rcv_q;
    total_d      = total_q;
    word_d       = word_q;
    err_d        = err_q;
    o_line_ready = 1'b0;
    o_dict_clear = 1'b0;
    o_word_valid = 1'b0;
    o_done       = 1'b0;

    // Returns are only legal while a line is in flight and not yet complete.
    if (i_len_valid) begin
      if (len_ok) begin
        total_d = total_q + len_sum;
        rcv_d   = rcv_q + 1'b1;
      end else begin
        err_d = 1'b1;
      end
    end

    case (state_q)
      ST_IDLE: begin
        o_line_ready = !i_reset;
        if (i_line_valid && !i_reset) begin
          line_d  = i_line;
          state_d = ST_CLEAR;
        end
      end
      ST_CLEAR: begin
        o_dict_clear = 1'b1;
        idx_d        = '0;
        rcv_d        = '0;
        total_d      = '0;
        state_d      = ST_ISSUE;
      end
      ST_ISSUE: begin
        if (!i_stall) begin
          o_word_valid = 1'b1;
          word_d       = pair_sel;
          idx_d        = idx_q + 1'b1;
          if (idx_q == IDX_W'(NUM_PAIRS - 1)) state_d = ST_DRAIN;
        end
      end
      ST_DRAIN: begin
        if (rcv_d == CNT_W'(NUM_PAIRS)) state_d = ST_DONE;
      end
      ST_DONE: begin
        o_done = 1'b1;
        if (i_done_ack) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // While stalled the last issued pair stays on the bus.
  assign o_word         = o_word_valid ? pair_sel : word_q;
  assign o_total_bits   = (state_q == ST_DONE) ? total_q : '0;
  assign o_compressible = (state_q == ST_DONE) && (total_q < TOT_W'(CACHE_LINE));
  assign o_busy         = (state_q != ST_IDLE);
  assign o_protocol_err = err_q;

endmodule
`default_nettype wire

// File: tb/tb_cpack_line_ctrl.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | tb_cpack_line_ctrl: directed self-checking bench for cpack_line_ctrl |
// | Rev 1.0                                                              |
// +----------------------------------------------------------------------+
module tb_cpack_line_ctrl;

  logic         clk = 1'b0;
  logic         i_reset, i_line_valid, o_line_ready;
  logic [511:0] i_line;
  logic [63:0]  o_word;
  logic         o_word_valid, o_dict_clear, i_stall, i_len_valid;
  logic [6:0]   i_length1, i_length2;
  logic         o_done;
  logic [9:0]   o_total_bits;
  logic         o_compressible, i_done_ack, o_busy, o_protocol_err;

  int n_cmp = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  cpack_line_ctrl dut (
    .i_clk          (clk),
    .i_reset        (i_reset),
    .i_line_valid   (i_line_valid),
    .o_line_ready   (o_line_ready),
    .i_line         (i_line),
    .o_word         (o_word),
    .o_word_valid   (o_word_valid),
    .o_dict_clear   (o_dict_clear),
    .i_stall        (i_stall),
    .i_len_valid    (i_len_valid),
    .i_length1      (i_length1),
    .i_length2      (i_length2),
    .o_done         (o_done),
    .o_total_bits   (o_total_bits),
    .o_compressible (o_compressible),
    .i_done_ack     (i_done_ack),
    .o_busy         (o_busy),
    .o_protocol_err (o_protocol_err)
  );

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic logic [511:0] make_line(input logic [31:0] base);
    logic [511:0] l;
    for (int k = 0; k < 16; k++) l[k*32 +: 32] = base + 32'(k) * 32'h0101_0011;
    return l;
  endfunction

  // Called with the DUT idle at negedge+1; returns at negedge+1 with the DUT idle.
  task automatic run_line(input string tag, input logic [511:0] line,
                          input logic [6:0] l1, input logic [6:0] l2,
                          input int stall_after, input int stall_n, input int reset_pair,
                          input logic [9:0] exp_total, input logic exp_comp, input logic exp_err);
    int issued = 0, first_n = -1, last_n = -1, last_len = -1, done_n = -1;
    int stall_left = stall_n, stalled = 0;
    logic p0 = 1'b0, p1 = 1'b0;
    logic [63:0] prev = '0;
    logic [63:0] exp_pair;

    chk({tag, "/ready"}, 64'(o_line_ready), 64'd1);
    i_line = line; i_line_valid = 1'b1; i_length1 = l1; i_length2 = l2;
    @(negedge clk); i_line_valid = 1'b0; #1;
    chk({tag, "/clear"}, {61'd0, o_dict_clear, o_busy, o_word_valid}, 64'b110);

    for (int n = 0; n < 40; n++) begin
      @(negedge clk);
      i_len_valid = p1;
      if (i_len_valid) last_len = n;
      i_stall = (issued == stall_after) && (stall_left > 0);
      if (i_stall) stall_left--;
      if (reset_pair >= 0 && issued == reset_pair) i_reset = 1'b1;
      #1;
      if (i_reset) begin
        @(negedge clk); i_reset = 1'b0; i_len_valid = 1'b0; i_stall = 1'b0; #1;
        chk({tag, "/rst_flags"}, {58'd0, o_done, o_word_valid, o_busy, o_dict_clear,
                                  o_compressible, o_protocol_err}, 64'd0);
        chk({tag, "/rst_word"}, o_word, 64'd0);
        chk({tag, "/rst_total"}, 64'(o_total_bits), 64'd0);
        chk({tag, "/rst_ready"}, 64'(o_line_ready), 64'd1);
        return;
      end
      if (o_done) begin
        done_n = n;
        break;
      end
      if (i_stall) begin
        chk({tag, "/stall_valid"}, 64'(o_word_valid), 64'd0);
        chk({tag, "/stall_hold"}, o_word, prev);
        stalled++;
      end
      if (o_word_valid) begin
        exp_pair = line[issued*64 +: 64];
        chk({tag, "/pair"}, o_word, exp_pair);
        prev = exp_pair;
        if (first_n < 0) first_n = n;
        last_n = n;
        issued++;
      end
      p1 = p0;
      p0 = o_word_valid;
    end

    chk({tag, "/done_seen"}, 64'(done_n >= 0), 64'd1);
    chk({tag, "/done_lat"}, 64'(done_n), 64'(last_len + 1));
    chk({tag, "/issued"}, 64'(issued), 64'd8);
    chk({tag, "/total"}, 64'(o_total_bits), 64'(exp_total));
    chk({tag, "/compressible"}, 64'(o_compressible), 64'(exp_comp));
    chk({tag, "/proto_err"}, 64'(o_protocol_err), 64'(exp_err));
    if (stall_n == 0) chk({tag, "/window"}, {32'(first_n), 32'(last_n)}, {32'd0, 32'd7});
    else              chk({tag, "/stall_cycles"}, 64'(stalled), 64'(stall_n));

    @(negedge clk); i_len_valid = 1'b0; #1;
    chk({tag, "/done_hold"}, {53'd0, o_done, o_total_bits}, {53'd1, exp_total});
    i_done_ack = 1'b1;
    @(negedge clk); i_done_ack = 1'b0; #1;
    chk({tag, "/after_ack"}, {62'd0, o_line_ready, o_done}, 64'b10);
  endtask

  initial begin
    i_reset = 1'b1; i_line_valid = 1'b0; i_line = '0; i_stall = 1'b0;
    i_len_valid = 1'b0; i_length1 = '0; i_length2 = '0; i_done_ack = 1'b0;
    repeat (2) @(negedge clk);
    #1;
    chk("reset/ready_low", 64'(o_line_ready), 64'd0);
    i_reset = 1'b0; #1;
    chk("reset/ready", 64'(o_line_ready), 64'd1);
    chk("reset/flags", {58'd0, o_done, o_word_valid, o_busy, o_dict_clear,
                        o_compressible, o_protocol_err}, 64'd0);
    chk("reset/total", 64'(o_total_bits), 64'd0);

    run_line("zero",  '0,                        7'd2,  7'd2,  -1, 0, -1, 10'd32,  1'b1, 1'b0);
    run_line("miss",  make_line(32'hDEAD_0001),  7'd34, 7'd34, -1, 0, -1, 10'd544, 1'b0, 1'b0);
    run_line("mix6",  make_line(32'h1234_5678),  7'd6,  7'd34, -1, 0, -1, 10'd320, 1'b1, 1'b0);
    run_line("eq512", make_line(32'h8000_0F0F),  7'd30, 7'd34, -1, 0, -1, 10'd512, 1'b0, 1'b0);
    run_line("stall", make_line(32'hCAFE_0100),  7'd2,  7'd2,   4, 3, -1, 10'd32,  1'b1, 1'b0);
    run_line("rst",   make_line(32'h0BAD_F00D),  7'd6,  7'd34, -1, 0,  5, 10'd0,   1'b0, 1'b0);
    run_line("post",  make_line(32'h5555_AAAA),  7'd34, 7'd34, -1, 0, -1, 10'd544, 1'b0, 1'b0);

    // Spurious return while idle: flagged, ignored, and sticky across lines.
    i_len_valid = 1'b1; i_length1 = 7'd34; i_length2 = 7'd34;
    @(negedge clk); i_len_valid = 1'b0; #1;
    chk("spur/err", 64'(o_protocol_err), 64'd1);
    chk("spur/idle", {62'd0, o_busy, o_line_ready}, 64'b01);
    run_line("b2b1",  make_line(32'h0000_1111),  7'd2,  7'd2,  -1, 0, -1, 10'd32,  1'b1, 1'b1);
    run_line("b2b2",  make_line(32'h2222_0000),  7'd6,  7'd34, -1, 0, -1, 10'd320, 1'b1, 1'b1);

    i_reset = 1'b1;
    @(negedge clk); i_reset = 1'b0; #1;
    chk("final/err_cleared", 64'(o_protocol_err), 64'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
`default_nettype wire
